// File: rtl/edge_detector.sv
// Single-clock edge detector: turns a level input into a one-cycle pulse on the
// selected transition(s), with an optional front-end synchronizer chain.
`timescale 1ns/100ps
module edge_detector #(
  parameter int p_RISE_DETECTOR = 1,
  parameter int p_BOTH_EDGES    = 0,
  parameter int p_SYNC_STAGES   = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_signal,
  output logic o_edge,
  output logic o_level
);

  logic s_in;
  logic prev_q,   prev_d;
  logic primed_q, primed_d;
  logic edge_q,   edge_d;
  logic level_q,  level_d;
  logic match;

  generate
    if (p_SYNC_STAGES == 0) begin : g_no_sync
      assign s_in = i_signal;
    end else begin : g_sync
      logic [p_SYNC_STAGES-1:0] sync_q;
      logic [p_SYNC_STAGES-1:0] sync_d;

      // Shift the raw input one stage deeper into the chain every cycle.
      always_comb begin
        sync_d    = sync_q;
        sync_d[0] = i_signal;
        for (int i = 1; i < p_SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      // Synchronizer flops, cleared with the rest of the state.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          sync_q <= {p_SYNC_STAGES{1'b0}};
        end else begin
          sync_q <= sync_d;
        end
      end

      assign s_in = sync_q[p_SYNC_STAGES-1];
    end
  endgenerate

  // Transition match and next-state; the first sample after reset only loads history.
  always_comb begin
    prev_d   = s_in;
    level_d  = s_in;
    primed_d = 1'b1;
    if (p_BOTH_EDGES != 0) begin
      match = s_in ^ prev_q;
    end else if (p_RISE_DETECTOR != 0) begin
      match = s_in & ~prev_q;
    end else begin
      match = ~s_in & prev_q;
    end
    if (primed_q) begin
      edge_d = match;
    end else begin
      edge_d = 1'b0;
    end
  end

  // Detector state and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
      edge_q   <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
      edge_q   <= edge_d;
      level_q  <= level_d;
    end
  end

  assign o_edge  = edge_q;
  assign o_level = level_q;

endmodule

// File: tb/tb_edge_detector.sv
// Scoreboard bench for edge_detector: four instances (falling, rising, both-edge,
// rising with 2 sync stages) share one stimulus stream; expectations come from a sample-history model.
`timescale 1ns/100ps
module tb_edge_detector;

  typedef struct packed {
    logic [3:0] e;
    logic [3:0] l;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_signal = 1'b0;
  logic e_fall, l_fall, e_rise, l_rise, e_both, l_both, e_sync, l_sync;

  int checks = 0;
  int failures = 0;
  int pulses [4] = '{0, 0, 0, 0};
  bit counting = 1'b0;
  int nst  [4] = '{0, 0, 0, 2};
  int mode [4] = '{0, 1, 2, 1};   // 0 fall, 1 rise, 2 both
  bit hist_sig [$];
  bit hist_rst [$];
  exp_t sb [$];
  logic ss [4];

  edge_detector #(.p_RISE_DETECTOR(0), .p_BOTH_EDGES(0), .p_SYNC_STAGES(0)) u_fall (
    .i_clk(i_clk), .i_rst(i_rst), .i_signal(i_signal), .o_edge(e_fall), .o_level(l_fall));
  edge_detector #(.p_RISE_DETECTOR(1), .p_BOTH_EDGES(0), .p_SYNC_STAGES(0)) u_rise (
    .i_clk(i_clk), .i_rst(i_rst), .i_signal(i_signal), .o_edge(e_rise), .o_level(l_rise));
  edge_detector #(.p_RISE_DETECTOR(1), .p_BOTH_EDGES(1), .p_SYNC_STAGES(0)) u_both (
    .i_clk(i_clk), .i_rst(i_rst), .i_signal(i_signal), .o_edge(e_both), .o_level(l_both));
  edge_detector #(.p_RISE_DETECTOR(1), .p_BOTH_EDGES(0), .p_SYNC_STAGES(2)) u_sync (
    .i_clk(i_clk), .i_rst(i_rst), .i_signal(i_signal), .o_edge(e_sync), .o_level(l_sync));

  always #1 i_clk = ~i_clk;

  // Value seen by the detector at edge j: the input sampled n edges earlier, zero if a reset intervened.
  function automatic bit s_in_at(int j, int n);
    if (n == 0) return hist_sig[j];
    if (j - n < 0) return 1'b0;
    for (int k = j - n; k < j; k++) begin
      if (hist_rst[k]) return 1'b0;
    end
    return hist_sig[j-n];
  endfunction

  // Expected {edge, level} just after edge j.
  function automatic logic [1:0] exp_at(int j, int n, int md);
    bit s, p, e;
    if (hist_rst[j]) return 2'b00;
    s = s_in_at(j, n);
    if (j == 0 || hist_rst[j-1]) return {1'b0, s};
    p = s_in_at(j - 1, n);
    case (md)
      0:       e = !s && p;
      1:       e = s && !p;
      default: e = s ^ p;
    endcase
    return {e, s};
  endfunction

  task automatic step(input bit rst, input bit sig);
    exp_t x;
    exp_t y;
    logic [1:0] r;
    logic [3:0] oe;
    logic [3:0] ol;
    int j;
    i_rst = rst;
    i_signal = sig;
    hist_sig.push_back(sig);
    hist_rst.push_back(rst);
    j = hist_sig.size() - 1;
    for (int m = 0; m < 4; m++) begin
      r = exp_at(j, nst[m], mode[m]);
      x.e[m] = r[1];
      x.l[m] = r[0];
    end
    sb.push_back(x);
    @(posedge i_clk);
    @(negedge i_clk);
    y = sb.pop_front();
    oe = {e_sync, e_both, e_rise, e_fall};
    ol = {l_sync, l_both, l_rise, l_fall};
    for (int m = 0; m < 4; m++) begin
      checks++;
      assert (oe[m] === y.e[m]) else begin
        failures++;
        $error("FAIL edge[%0d] cycle %0d: observed %b expected %b", m, j, oe[m], y.e[m]);
      end
      checks++;
      assert (ol[m] === y.l[m]) else begin
        failures++;
        $error("FAIL level[%0d] cycle %0d: observed %b expected %b", m, j, ol[m], y.l[m]);
      end
      if (counting && oe[m] === 1'b1) pulses[m]++;
    end
  endtask

  initial begin
    int exp_p [4];
    bit v;
    exp_p = '{5, 5, 10, 5};

    // reset held several cycles, input low
    @(negedge i_clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // 10 toggles, each level held for two cycles, plus flush for the sync instance
    counting = 1'b1;
    v = 1'b0;
    for (int t = 0; t < 10; t++) begin
      v = ~v;
      step(1'b0, v);
      step(1'b0, v);
    end
    for (int i = 0; i < 3; i++) step(1'b0, v);
    counting = 1'b0;
    for (int m = 0; m < 4; m++) begin
      checks++;
      assert (pulses[m] === exp_p[m]) else begin
        failures++;
        $error("FAIL pulse_count[%0d]: observed %0d expected %0d", m, pulses[m], exp_p[m]);
      end
    end

    // reset asserted while the rising pulse is high, input stays high into release
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    checks++;
    assert (e_rise === 1'b1) else begin
      failures++;
      $error("FAIL pre_reset_pulse: observed %b expected 1", e_rise);
    end
    step(1'b1, 1'b1);
    checks++;
    assert (e_rise === 1'b0 && l_rise === 1'b0) else begin
      failures++;
      $error("FAIL mid_reset: observed edge %b level %b expected 0 0", e_rise, l_rise);
    end
    step(1'b1, 1'b1);
    pulses[1] = 0;
    counting = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    counting = 1'b0;
    checks++;
    assert (pulses[1] === 1) else begin
      failures++;
      $error("FAIL priming: observed %0d pulses expected 1", pulses[1]);
    end

    // sub-cycle glitch between rising edges
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    i_signal = 1'b1;
    #0.4;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // sync latency: single step before edge k, pulse only after edge k+2
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1);
      ss[i] = e_sync;
    end
    checks++;
    assert (ss[0] === 1'b0 && ss[1] === 1'b0 && ss[2] === 1'b1 && ss[3] === 1'b0) else begin
      failures++;
      $error("FAIL sync_latency: observed %b%b%b%b expected 0010", ss[0], ss[1], ss[2], ss[3]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
